sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_pkg.sv | 69 ++++++
 rtl/sha256_padder_if.sv | 25 ++
 rtl/sha256_padder.sv | 130 +++++++++++++
 tb/tb_sha256_padder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and padding helpers for the SHA-256 message padder.
package sha256_pkg;

    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LEN_W   = 64;
    localparam int unsigned WORDS   = BLOCK_W / WORD_W;
    localparam int unsigned WIDX_W  = 4;
    localparam int unsigned BYTES_W = 3;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [WORD_W-1:0]             word_t;
    typedef logic [WORDS-1:0][WORD_W-1:0]  block_t;
    typedef logic [LEN_W-1:0]              len_t;
    typedef logic [WIDX_W-1:0]             widx_t;
    typedef logic [BYTES_W-1:0]            nbytes_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_EMIT,
        ST_EXTRA,
        ST_EMIT_FINAL
    } state_e;

    // Byte counts above a full word collapse to a full word.
    function automatic nbytes_t sat_bytes(input nbytes_t nb);
        return (nb > nbytes_t'(4)) ? nbytes_t'(4) : nb;
    endfunction

    // Keep the leading nb bytes, pad byte right after them, zeros below.
    function automatic word_t mask_pad_word(input word_t d, input nbytes_t nb);
        word_t r;
        int    n;
        r = '0;
        n = int'(nb);
        for (int b = 0; b < 4; b++) begin
            if (b < n) begin
                r[31-8*b -: 8] = d[31-8*b -: 8];
            end else if (b == n) begin
                r[31-8*b -: 8] = PAD_BYTE;
            end
        end
        return r;
    endfunction

    // Merge the final word into the block: earlier words kept, pad inserted,
    // everything after the pad position cleared. A full last word pushes the
    // pad byte into the next word when one exists in this block.
    function automatic block_t pad_last(input block_t blk, input widx_t widx,
                                        input word_t d, input nbytes_t nb);
        block_t r;
        int     w;
        w = int'(widx);
        for (int i = 0; i < int'(WORDS); i++) begin
            if (i < w) begin
                r[i] = blk[i];
            end else if (i == w) begin
                r[i] = mask_pad_word(d, nb);
            end else if ((i == w + 1) && (nb == nbytes_t'(4))) begin
                r[i] = {PAD_BYTE, 24'h0};
            end else begin
                r[i] = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Word-in / block-out handshake bundle between message source, padder and hash core.
interface sha256_padder_if;

    logic                      in_valid;
    logic                      in_ready;
    sha256_pkg::word_t         in_data;
    logic                      in_last;
    sha256_pkg::nbytes_t       in_bytes;

    logic                      out_valid;
    logic                      out_ready;
    sha256_pkg::block_t        out_block;
    logic                      out_final;

    modport master (
        output in_valid, in_data, in_last, in_bytes, out_ready,
        input  in_ready, out_valid, out_block, out_final
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, out_ready,
        output in_ready, out_valid, out_block, out_final
    );

endinterface

// File: rtl/sha256_padder.sv
// Collects 32-bit message words into 512-bit SHA-256 blocks and appends
// the 0x80 marker, zero fill and 64-bit bit length.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    sha256_padder_if.slave  bus
);

    state_e  state_q,     state_d;
    widx_t   widx_q,      widx_d;
    len_t    len_q,       len_d;
    block_t  blk_q,       blk_d;
    logic    extra_q,     extra_d;
    logic    extra_pad_q, extra_pad_d;
    logic    in_ready_q,  in_ready_d;
    logic    out_valid_q, out_valid_d;
    logic    out_final_q, out_final_d;

    nbytes_t     nb_c;
    logic [6:0]  pad_pos_c;
    logic        accept_c;
    logic        out_hs_c;
    len_t        len_inc_c;

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        len_d       = len_q;
        blk_d       = blk_q;
        extra_d     = extra_q;
        extra_pad_d = extra_pad_q;

        nb_c      = sat_bytes(bus.in_bytes);
        pad_pos_c = 7'({widx_q, 2'b00}) + 7'(nb_c);
        accept_c  = bus.in_valid && in_ready_q;
        out_hs_c  = out_valid_q && bus.out_ready;
        len_inc_c = bus.in_last ? LEN_W'({nb_c, 3'b000}) : LEN_W'(WORD_W);

        case (state_q)
            ST_FILL: begin
                if (accept_c) begin
                    len_d  = len_q + len_inc_c;
                    widx_d = widx_q + widx_t'(1);
                    if (!bus.in_last) begin
                        blk_d[widx_q] = bus.in_data;
                        if (widx_q == widx_t'(WORDS - 1)) begin
                            state_d = ST_EMIT;
                            extra_d = 1'b0;
                        end
                    end else begin
                        blk_d = pad_last(blk_q, widx_q, bus.in_data, nb_c);
                        if (pad_pos_c <= 7'd55) begin
                            // Length fits behind the pad in this block.
                            blk_d[WORDS-2] = len_d[LEN_W-1:WORD_W];
                            blk_d[WORDS-1] = len_d[WORD_W-1:0];
                            state_d        = ST_EMIT_FINAL;
                        end else begin
                            state_d     = ST_EMIT;
                            extra_d     = 1'b1;
                            extra_pad_d = (pad_pos_c == 7'd64);
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (out_hs_c) begin
                    state_d = extra_q ? ST_EXTRA : ST_FILL;
                end
            end
            ST_EXTRA: begin
                // Trailing block: zeros, optional leading pad, then the length.
                blk_d = '0;
                if (extra_pad_q) begin
                    blk_d[0] = {PAD_BYTE, 24'h0};
                end
                blk_d[WORDS-2] = len_q[LEN_W-1:WORD_W];
                blk_d[WORDS-1] = len_q[WORD_W-1:0];
                extra_d        = 1'b0;
                extra_pad_d    = 1'b0;
                state_d        = ST_EMIT_FINAL;
            end
            ST_EMIT_FINAL: begin
                if (out_hs_c) begin
                    len_d   = '0;
                    widx_d  = '0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        in_ready_d  = (state_d == ST_FILL);
        out_valid_d = (state_d == ST_EMIT) || (state_d == ST_EMIT_FINAL);
        out_final_d = (state_d == ST_EMIT_FINAL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FILL;
            widx_q      <= '0;
            len_q       <= '0;
            blk_q       <= '0;
            extra_q     <= 1'b0;
            extra_pad_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_final_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            len_q       <= len_d;
            blk_q       <= blk_d;
            extra_q     <= extra_d;
            extra_pad_q <= extra_pad_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_final_q <= out_final_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = blk_q;
    assign bus.out_final = out_final_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed message table plus random messages,
// checked against a byte-level SHA-256 padding model.
module tb_sha256_padder;
    import sha256_pkg::*;

    logic clk;
    logic reset;
    sha256_padder_if bus();

    sha256_padder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] msg_q[$];
    block_t     exp_q[$];
    block_t     rx_q[$];
    logic       rx_fin[$];
    int         rx_cyc[$];

    int      mode  = 0;   // 0 ready, 1 random, 2 hold 10 cycles, 3 never
    bit      gaps  = 1'b0;
    bit      split = 1'b0;
    nbytes_t nb_over = '0;

    typedef struct {
        int    len;
        bit    abc;
        bit    split;
        nbytes_t nb_over;
        int    nblk;
        bit    ext;
        word_t f_w0;
        word_t f_w14;
        word_t l_w0;
        word_t l_w15;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: standard byte-oriented padding, then cut into 64-byte blocks.
    task automatic build_exp();
        logic [7:0] b[$];
        len_t       bl;
        block_t     blk;
        b  = msg_q;
        bl = 64'(msg_q.size()) << 3;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int k = 7; k >= 0; k--) b.push_back(bl[8*k+7 -: 8]);
        exp_q.delete();
        for (int k = 0; k < b.size() / 64; k++) begin
            for (int i = 0; i < 16; i++)
                blk[i] = {b[64*k+4*i], b[64*k+4*i+1], b[64*k+4*i+2], b[64*k+4*i+3]};
            exp_q.push_back(blk);
        end
    endtask

    task automatic drive_one(input word_t d, input logic last, input nbytes_t nb, output bit ok);
        int g;
        ok = 1'b0;
        @(negedge clk);
        if (gaps) begin
            g = int'($urandom_range(0, 3));
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.in_data  = word_t'($urandom);
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_bytes = nb;
        for (int t = 0; t < 4000; t++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL in_timeout: in_ready stayed 0, expected 1");
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_msg();
        int      len, nw, idx;
        nbytes_t nb_last;
        word_t   w;
        bit      ok;
        len = msg_q.size();
        if (len == 0) begin
            nw = 1; nb_last = '0;
        end else if (len % 4 == 0) begin
            nw      = split ? len / 4 + 1 : len / 4;
            nb_last = split ? nbytes_t'(0) : nbytes_t'(4);
        end else begin
            nw = len / 4 + 1; nb_last = nbytes_t'(len % 4);
        end
        if (nb_over != '0) nb_last = nb_over;
        for (int k = 0; k < nw; k++) begin
            for (int b = 0; b < 4; b++) begin
                idx = 4 * k + b;
                w[31-8*b -: 8] = (idx < len) ? msg_q[idx] : 8'($urandom);
            end
            drive_one(w, (k == nw - 1), (k == nw - 1) ? nb_last : nbytes_t'($urandom), ok);
            if (!ok) return;
            if ((k == nw - 1) || (k % 16 == 15)) begin
                @(negedge clk);
                chk("out_valid_latency", 512'(bus.out_valid), 512'(1));
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_blocks(input int n);
        for (int t = 0; t < 6000 && rx_q.size() < n; t++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("block_count", 512'(rx_q.size()), 512'(n));
    endtask

    task automatic run_msg();
        int n;
        rx_q.delete(); rx_fin.delete(); rx_cyc.delete();
        build_exp();
        send_msg();
        n = exp_q.size();
        wait_blocks(n);
        for (int k = 0; k < n && k < rx_q.size(); k++) begin
            chk("block", 512'(rx_q[k]), 512'(exp_q[k]));
            chk("final", 512'(rx_fin[k]), 512'(k == n - 1));
        end
    endtask

    // Downstream sink: applies the ready policy and checks hold behaviour.
    bit     held = 1'b0;
    int     hold_cnt = 0;
    block_t prev_blk;
    logic   prev_fin;
    bit     rdy;

    initial begin : sink
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held = 1'b0;
                hold_cnt = 0;
                bus.out_ready = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", 512'(bus.out_valid), 512'(1));
                    chk("hold_block", 512'(bus.out_block), 512'(prev_blk));
                    chk("hold_final", 512'(bus.out_final), 512'(prev_fin));
                end
                if (bus.out_valid) begin
                    chk("in_ready_while_out", 512'(bus.in_ready), 512'(0));
                    case (mode)
                        0: rdy = 1'b1;
                        1: rdy = ($urandom_range(0, 1) == 1);
                        2: begin
                            rdy = (hold_cnt >= 10);
                            if (!rdy) hold_cnt++;
                        end
                        default: rdy = 1'b0;
                    endcase
                    bus.out_ready = rdy;
                    if (rdy) begin
                        rx_q.push_back(bus.out_block);
                        rx_fin.push_back(bus.out_final);
                        rx_cyc.push_back(cyc);
                        held = 1'b0;
                        hold_cnt = 0;
                    end else begin
                        held = 1'b1;
                        prev_blk = bus.out_block;
                        prev_fin = bus.out_final;
                    end
                end else begin
                    held = 1'b0;
                    bus.out_ready = (mode == 0) || ((mode == 1) && ($urandom_range(0, 1) == 1));
                end
            end
        end
    end

    block_t abc_blk;
    bit     ok_w;
    int     rlen;

    initial begin
        tbl[0]  = '{3,   1'b1, 1'b0, 3'd0, 1, 1'b0, 32'h61626380, 32'h0,        32'h61626380, 32'h18};
        tbl[1]  = '{0,   1'b0, 1'b0, 3'd0, 1, 1'b0, 32'h80000000, 32'h0,        32'h80000000, 32'h0};
        tbl[2]  = '{1,   1'b0, 1'b0, 3'd0, 1, 1'b0, 32'h00800000, 32'h0,        32'h00800000, 32'h8};
        tbl[3]  = '{52,  1'b0, 1'b0, 3'd0, 1, 1'b0, 32'h00010203, 32'h0,        32'h00010203, 32'h1A0};
        tbl[4]  = '{55,  1'b0, 1'b0, 3'd0, 1, 1'b0, 32'h00010203, 32'h0,        32'h00010203, 32'h1B8};
        tbl[5]  = '{56,  1'b0, 1'b0, 3'd0, 2, 1'b1, 32'h00010203, 32'h80000000, 32'h0,        32'h1C0};
        tbl[6]  = '{60,  1'b0, 1'b0, 3'd0, 2, 1'b1, 32'h00010203, 32'h38393A3B, 32'h0,        32'h1E0};
        tbl[7]  = '{64,  1'b0, 1'b0, 3'd0, 2, 1'b1, 32'h00010203, 32'h38393A3B, 32'h80000000, 32'h200};
        tbl[8]  = '{64,  1'b0, 1'b1, 3'd0, 2, 1'b0, 32'h00010203, 32'h38393A3B, 32'h80000000, 32'h200};
        tbl[9]  = '{8,   1'b0, 1'b0, 3'd7, 1, 1'b0, 32'h00010203, 32'h0,        32'h00010203, 32'h40};
        tbl[10] = '{120, 1'b0, 1'b0, 3'd0, 3, 1'b1, 32'h00010203, 32'h38393A3B, 32'h0,        32'h3C0};

        abc_blk     = '0;
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.in_bytes = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  512'(bus.in_ready),  512'(0));
        chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
        chk("rst_out_final", 512'(bus.out_final), 512'(0));
        chk("rst_out_block", 512'(bus.out_block), 512'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 512'(bus.in_ready), 512'(1));

        // Directed table, sink always ready.
        mode = 0; gaps = 1'b0;
        for (int v = 0; v < 11; v++) begin
            msg_q.delete();
            if (tbl[v].abc) begin
                msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
            end else begin
                for (int i = 0; i < tbl[v].len; i++) msg_q.push_back(8'(i));
            end
            split   = tbl[v].split;
            nb_over = tbl[v].nb_over;
            run_msg();
            chk("tbl_nblk", 512'(rx_q.size()), 512'(tbl[v].nblk));
            if (rx_q.size() == tbl[v].nblk) begin
                chk("tbl_first_w0",  512'(rx_q[0][0]),  512'(tbl[v].f_w0));
                chk("tbl_first_w14", 512'(rx_q[0][14]), 512'(tbl[v].f_w14));
                chk("tbl_last_w0",   512'(rx_q[tbl[v].nblk-1][0]),  512'(tbl[v].l_w0));
                chk("tbl_last_w15",  512'(rx_q[tbl[v].nblk-1][15]), 512'(tbl[v].l_w15));
                if (tbl[v].ext)
                    chk("extra_latency",
                        512'(rx_cyc[tbl[v].nblk-1] - rx_cyc[tbl[v].nblk-2]), 512'(2));
            end
        end
        split = 1'b0; nb_over = '0;

        // Long back-pressure on every block with gapped input.
        mode = 2; gaps = 1'b1;
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
        run_msg();
        msg_q.delete();
        for (int i = 0; i < 150; i++) msg_q.push_back(8'($urandom));
        run_msg();

        // Reset mid-message and mid-emit, then "abc" must come out clean.
        mode = 0; gaps = 1'b0;
        rx_q.delete(); rx_fin.delete(); rx_cyc.delete();
        for (int k = 0; k < 7; k++) drive_one(word_t'($urandom), 1'b0, '0, ok_w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midmsg_rst_in_ready", 512'(bus.in_ready), 512'(0));
        chk("midmsg_rst_block",    512'(bus.out_block), 512'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midmsg_in_ready_back", 512'(bus.in_ready), 512'(1));

        mode = 3;
        for (int k = 0; k < 16; k++) drive_one(word_t'($urandom), 1'b0, '0, ok_w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 50 && !bus.out_valid; t++) @(negedge clk);
        chk("midemit_valid", 512'(bus.out_valid), 512'(1));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midemit_rst_valid", 512'(bus.out_valid), 512'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mode = 0;
        @(negedge clk);
        chk("no_output_after_reset", 512'(rx_q.size()), 512'(0));
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        run_msg();
        if (rx_q.size() == 1) begin
            chk("abc_after_reset", 512'(rx_q[0]), 512'(abc_blk));
            chk("abc_after_reset_final", 512'(rx_fin[0]), 512'(1));
        end

        // Random messages, lengths biased around the block-size boundaries.
        gaps = 1'b1;
        for (int r = 0; r < 40; r++) begin
            rlen = ($urandom_range(0, 1) == 1) ? int'($urandom_range(50, 72))
                                               : int'($urandom_range(0, 200));
            msg_q.delete();
            for (int i = 0; i < rlen; i++) msg_q.push_back(8'($urandom));
            split   = (rlen % 4 == 0) && ($urandom_range(0, 1) == 1);
            nb_over = ((rlen > 0) && (rlen % 4 == 0) && !split && ($urandom_range(0, 1) == 1))
                      ? nbytes_t'($urandom_range(5, 7)) : nbytes_t'(0);
            mode    = int'($urandom_range(0, 2));
            run_msg();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
